// File: rtl/key_pkg.sv
// Shared state encoding, default timing and counter sizing for push-button conditioning.
package key_pkg;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_DOWN         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int CLK_HZ          = 50_000_000;
    localparam int DB_MS           = 20;
    localparam int LONG_MS         = 1000;
    localparam int DB_CYCLES_DEF   = (CLK_HZ / 1000) * DB_MS;
    localparam int LONG_CYCLES_DEF = (CLK_HZ / 1000) * LONG_MS;

    // Width needed to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for asynchronous inputs; both stages reset to RST_VAL.
module key_sync #(
    parameter int   WIDTH   = 1,
    parameter logic RST_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= {WIDTH{RST_VAL}};
            r_sync <= {WIDTH{RST_VAL}};
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/key_debounce.sv
// Debounces an active-low push-button into a clean level plus press/release/long-press pulses.
//   state          | meaning
//   IDLE           | released, waiting for key_s low
//   PRESS_WAIT     | key_s low, counting stable cycles before accepting press
//   DOWN           | press accepted, hold timer running
//   RELEASE_WAIT   | key_s high, counting stable cycles before accepting release
import key_pkg::*;

module key_debounce #(
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level_n,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int DB_W   = cnt_width(DB_CYCLES);
    localparam int HOLD_W = cnt_width(LONG_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic              w_key_s;
    key_state_t        r_state, w_state_nxt;
    logic [DB_W-1:0]   r_db_cnt, w_db_nxt;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
    logic              r_long_done, w_long_done_nxt;
    logic              r_level_n, w_level_n_nxt;
    logic              r_press, w_press_nxt;
    logic              r_release, w_release_nxt;
    logic              r_long, w_long_nxt;
    logic              w_hold_run;

    key_sync #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (key_in),
        .o_q   (w_key_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_db_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
            r_level_n   <= 1'b1;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_db_cnt    <= w_db_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_long_done <= w_long_done_nxt;
            r_level_n   <= w_level_n_nxt;
            r_press     <= w_press_nxt;
            r_release   <= w_release_nxt;
            r_long      <= w_long_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_db_nxt        = r_db_cnt;
        w_hold_nxt      = r_hold_cnt;
        w_long_done_nxt = r_long_done;
        w_level_n_nxt   = r_level_n;
        w_press_nxt     = 1'b0;
        w_release_nxt   = 1'b0;
        w_long_nxt      = 1'b0;
        w_hold_run      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (!w_key_s) begin
                    w_state_nxt = S_PRESS_WAIT;
                    w_db_nxt    = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (w_key_s) begin
                    w_state_nxt = S_IDLE;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt     = S_DOWN;
                    w_level_n_nxt   = 1'b0;
                    w_press_nxt     = 1'b1;
                    w_hold_nxt      = '0;
                    w_long_done_nxt = 1'b0;
                end else begin
                    w_db_nxt = r_db_cnt + 1'b1;
                end
            end
            S_DOWN: begin
                w_hold_run = 1'b1;
                if (w_key_s) begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_db_nxt    = '0;
                end
            end
            S_RELEASE_WAIT: begin
                w_hold_run = 1'b1;
                if (!w_key_s) begin
                    w_state_nxt = S_DOWN;
                end else if (r_db_cnt == DB_LAST) begin
                    // An accepted release suppresses a long-press due on the same edge.
                    w_state_nxt   = S_IDLE;
                    w_level_n_nxt = 1'b1;
                    w_release_nxt = 1'b1;
                    w_hold_run    = 1'b0;
                end else begin
                    w_db_nxt = r_db_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Long-press fires the edge after the timer saturates, once per press.
        if (w_hold_run) begin
            if (r_hold_cnt != HOLD_LAST) begin
                w_hold_nxt = r_hold_cnt + 1'b1;
            end else if (!r_long_done) begin
                w_long_nxt      = 1'b1;
                w_long_done_nxt = 1'b1;
            end
        end
    end

    assign key_level_n = r_level_n;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign key_long    = r_long;

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Front-end conditioning stage for a raw, bouncing, active-low push-button. Sits directly upstream of the beeper tone generator.
- Synchronises the raw key into clk, rejects bounce and glitches shorter than the debounce window, and produces three outputs:
  - a clean active-low level that feeds the beeper's key input directly;
  - single-cycle press and release pulses;
  - a single-cycle long-press pulse.

Parameters:
- DB_CYCLES, 1_000_000, stable-input cycles required to accept a transition (20 ms at 50 MHz); must be >= 2.
- LONG_CYCLES, 50_000_000, cycles after an accepted press before key_long fires (1 s at 50 MHz); must be >= 1.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous reset, active-low.
- key_in  in  1  raw button, active-low, asynchronous to clk, bouncy.
- key_level_n  out  1  debounced level, active-low (0 = pressed); feeds the beeper key input.
- key_press  out  1  one-cycle pulse when a press is accepted.
- key_release  out  1  one-cycle pulse when a release is accepted.
- key_long  out  1  one-cycle pulse, at most once per press.

Behaviour:
- Reset is asynchronous, active-low, on clk. While rst_n=0:
  - synchroniser flops = 1, state = IDLE, all counters = 0;
  - key_level_n = 1, key_press = 0, key_release = 0, key_long = 0.
- Synchroniser: 2-flop chain; key_s is the second flop output. FSM and counters use only key_s.
- FSM states: IDLE, PRESS_WAIT, DOWN, RELEASE_WAIT. All outputs are registered.
- IDLE:
  - key_s=0 -> PRESS_WAIT, db_cnt<=0.
- PRESS_WAIT:
  - key_s=1 -> IDLE (glitch rejected, no output change).
  - else db_cnt++.
  - db_cnt==DB_CYCLES-1 with key_s=0 -> DOWN, key_level_n<=0, key_press<=1 for one cycle, hold_cnt<=0.
- DOWN:
  - hold_cnt++ saturating at LONG_CYCLES-1.
  - Transition of hold_cnt to LONG_CYCLES-1 -> key_long<=1 for one cycle. Only one pulse per press; saturation prevents repeats.
  - key_s=1 -> RELEASE_WAIT, db_cnt<=0.
- RELEASE_WAIT:
  - hold_cnt keeps counting, and key_long may still fire here.
  - key_s=0 -> DOWN (bounce): no pulse, hold_cnt preserved.
  - else db_cnt++.
  - db_cnt==DB_CYCLES-1 with key_s=1 -> IDLE, key_level_n<=1, key_release<=1 for one cycle.
- Latency, counted from clock edge 0 (the first edge that samples a new stable key_in value):
  - key_level_n and the press/release pulse update at edge DB_CYCLES+2, provided key_in stays stable throughout.
  - key_long asserts LONG_CYCLES edges after the edge that asserted key_press.
- Simultaneous events:
  - If the release is accepted on the same edge hold_cnt would reach threshold, key_release wins and key_long is not asserted.
  - key_press and key_release are never high together.
- Wrap-around: db_cnt never exceeds DB_CYCLES-1 and hold_cnt saturates, so there is no counter overflow.
- Reset mid-operation (e.g. in DOWN):
  - outputs return to idle immediately and no key_release is emitted;
  - if the key is still held after rst_n rises, a full debounce occurs and key_press fires normally.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit.

Decomposition:
- Shared package key_pkg:
  - FSM state enum (2-bit);
  - default constants CLK_HZ=50_000_000, DB_MS=20, LONG_MS=1000, plus derived cycle counts.
- Sub-module key_sync: generic 2-flop synchroniser with reset value 1. It is reused by future key inputs.

Test Plan:
Run with DB_CYCLES=8, LONG_CYCLES=32.
1. Reset asserted with key_in=1 -> key_level_n=1, key_press=key_release=key_long=0 for the entire reset period and afterwards.
2. key_in driven 0 and held 20 cycles -> exactly one key_press pulse at edge 10; key_level_n=0 from edge 10 onward; no key_long.
3. key_in low for 5 cycles, then high -> no pulses; key_level_n stays 1.
4. After an accepted press, key_in toggles 1/0/1 with 2-cycle pulses, then stays 1 -> exactly one key_release, at edge 10 after the final rising sample; no extra key_press.
5. key_in held low 60 cycles -> key_press at edge 10 and a single key_long 32 edges later; no second key_long; one key_release after key_in returns high.
6. rst_n pulsed low while in DOWN with key_in held low -> key_level_n=1 asynchronously and no key_release; after rst_n rises, key_press at edge 10 and key_level_n=0.
